// File: rtl/mips32_pkg.sv
// Shared definitions for the mips32 program-load front end.
package mips32_pkg;

  localparam int         IMEM_DEPTH = 1024;
  localparam logic [5:0] OP_HALT    = 6'b111111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_RUN,
    ST_HALTED
  } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word packer: 2-bit byte index plus 32-bit assembly register.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  input  logic        i_flush,
  output logic        o_emit,
  output logic        o_flushing,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [1:0]  r_idx;
  logic [31:0] r_word;
  logic [31:0] r_out;
  logic        r_valid;
  logic [31:0] w_word_next;
  logic        w_last;
  logic        w_partial;

  // The byte accepted this cycle is merged before a flush so it lands in the emitted word.
  always_comb begin
    w_word_next = r_word;
    if (i_accept) begin
      case (r_idx)
        2'd0:    w_word_next[31:24] = i_byte;
        2'd1:    w_word_next[23:16] = i_byte;
        2'd2:    w_word_next[15:8]  = i_byte;
        default: w_word_next[7:0]   = i_byte;
      endcase
    end
  end

  assign w_last     = i_accept && (r_idx == 2'd3);
  assign w_partial  = i_accept ? (r_idx != 2'd3) : (r_idx != 2'd0);
  assign o_flushing = i_flush && w_partial;
  assign o_emit     = w_last || o_flushing;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_word  <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_idx   <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= o_emit;
      if (o_emit) begin
        r_out  <= w_word_next;
        r_word <= '0;
        r_idx  <= '0;
      end else if (i_accept) begin
        r_word <= w_word_next;
        r_idx  <= r_idx + 1'b1;
      end
    end
  end

  assign o_word_valid = r_valid;
  assign o_word       = r_out;

endmodule

// File: rtl/imem_loader.sv
// Program loader: byte stream to sequential imem writes, then run/halt control of the core.
module imem_loader
  import mips32_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic          load_done,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  input  logic          hlt,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          core_run,
  output logic [AW:0]   word_count,
  output logic          overflow
);

  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

  loader_state_t r_state;
  loader_state_t w_state_next;
  logic [AW:0]   r_count;
  logic [AW-1:0] r_addr;
  logic          r_overflow;
  logic          w_full;
  logic          w_accept;
  logic          w_flush_req;
  logic          w_load_enter;
  logic          w_emit;
  logic          w_flushing;

  assign w_full       = (r_count == L_DEPTH);
  assign byte_ready   = (r_state == ST_LOAD) && !w_full;
  assign w_accept     = byte_valid && byte_ready;
  assign w_flush_req  = (r_state == ST_LOAD) && load_done && !w_full;
  assign w_load_enter = load_start &&
                        ((r_state == ST_IDLE) || (r_state == ST_RUN) || (r_state == ST_HALTED));

  // Flush word is registered on the load_done edge, so imem_we is high during FLUSH.
  byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_load_enter),
    .i_accept     (w_accept),
    .i_byte       (byte_in),
    .i_flush      (w_flush_req),
    .o_emit       (w_emit),
    .o_flushing   (w_flushing),
    .o_word_valid (imem_we),
    .o_word       (imem_wdata)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (load_start) w_state_next = ST_LOAD;
      ST_LOAD:   if (load_done)  w_state_next = w_flushing ? ST_FLUSH : ST_RUN;
      ST_FLUSH:  w_state_next = ST_RUN;
      ST_RUN: begin
        if (load_start)  w_state_next = ST_LOAD;
        else if (hlt)    w_state_next = ST_HALTED;
      end
      ST_HALTED: if (load_start) w_state_next = ST_LOAD;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_addr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_load_enter) begin
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_emit) begin
          r_addr  <= r_count[AW-1:0];
          r_count <= r_count + 1'b1;
        end
        if ((r_state == ST_LOAD) && w_full && byte_valid) r_overflow <= 1'b1;
      end
    end
  end

  assign imem_addr  = r_addr;
  assign core_run   = (r_state == ST_RUN);
  assign word_count = r_count;
  assign overflow   = r_overflow;

endmodule
